// File: rtl/gpio_mul_popcnt.sv
// Bus-mapped coprocessor: sequential shift-add multiply (one operand bit per clk), then a popcount of the result word.
// Latency: START accepted in cycle N, ready reads 1 from cycle N+OPW+3; sdata_out is registered one clk after srd.
// Backpressure: none; a START outside IDLE is dropped and raises sticky err, operand writes are always accepted.
module gpio_mul_popcnt #(
    parameter int          OPW  = 24,
    parameter int          RW   = 32,
    parameter logic [15:0] BASE = 16'h0380
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    input  logic [31:0] gpio_in,
    input  logic        gpio_latch,
    output logic [31:0] gpio_in_s_insp,
    output logic [31:0] gpio_out
);

    localparam int PW = 2 * OPW;
    localparam int CW = (OPW > 1) ? $clog2(OPW) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [15:0] ADDR_A1   = BASE + 16'h0000;
    localparam logic [15:0] ADDR_A2   = BASE + 16'h0008;
    localparam logic [15:0] ADDR_W    = BASE + 16'h0010;
    localparam logic [15:0] ADDR_L    = BASE + 16'h0018;
    localparam logic [15:0] ADDR_CTRL = BASE + 16'h0020;
    localparam logic [15:0] ADDR_GPIN = BASE + 16'h0028;

    logic [1:0]     state;
    logic [CW-1:0]  bit_idx;
    logic [OPW-1:0] a1_shadow, a2_shadow;
    logic [OPW-1:0] a1_work, a2_work;
    logic [PW-1:0]  acc;
    logic [31:0]    w_reg, l_reg;
    logic           valid, err;
    logic           gpio_latch_q;

    logic           ready;
    logic           start_req, start_ok;
    logic [PW-1:0]  a1_ext, addend;
    logic [63:0]    p_ext;
    logic [31:0]    w_next, l_next;
    logic           valid_next;
    logic [31:0]    rd_dat;
    logic           unused_bits;

    // Upper write-data bits above OPW are intentionally ignored.
    assign unused_bits = ^sdata_in;

    function automatic logic [31:0] popcnt32(input logic [31:0] v);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

    assign ready     = (state == S_IDLE);
    assign start_req = swr && (saddress == ADDR_CTRL) && sdata_in[0];
    assign start_ok  = start_req && ready;

    // Partial product for the current multiplier bit and the result-word split of the accumulator.
    always_comb begin
        a1_ext     = PW'(a1_work);
        addend     = a2_work[bit_idx] ? (a1_ext << bit_idx) : '0;
        p_ext      = 64'(acc);
        w_next     = 32'(p_ext[RW-1:0]);
        valid_next = ((p_ext >> RW) == 64'd0);
        l_next     = popcnt32(w_reg);
    end

    // Shadow operand registers: host writes land here at any time.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            a1_shadow <= '0;
            a2_shadow <= '0;
        end else if (swr) begin
            if (saddress == ADDR_A1) a1_shadow <= sdata_in[OPW-1:0];
            if (saddress == ADDR_A2) a2_shadow <= sdata_in[OPW-1:0];
        end
    end

    // Control FSM, datapath and result registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= S_IDLE;
            bit_idx  <= '0;
            a1_work  <= '0;
            a2_work  <= '0;
            acc      <= '0;
            w_reg    <= '0;
            l_reg    <= '0;
            valid    <= 1'b1;
            err      <= 1'b0;
            gpio_out <= '0;
        end else begin
            if (start_req && !ready) err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        // Working copies isolate the running op from later shadow writes.
                        a1_work <= a1_shadow;
                        a2_work <= a2_shadow;
                        acc     <= '0;
                        bit_idx <= '0;
                        err     <= 1'b0;
                        state   <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc <= acc + addend;
                    if (bit_idx == CW'(OPW - 1)) begin
                        state <= S_CNT;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                S_CNT: begin
                    w_reg <= w_next;
                    valid <= valid_next;
                    state <= S_DONE;
                end
                default: begin
                    l_reg    <= l_next;
                    gpio_out <= gpio_out + 32'd1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    // Read mux; L read during DONE bypasses to the value being written this clk.
    always_comb begin
        rd_dat = '0;
        case (saddress)
            ADDR_W:    rd_dat = w_reg;
            ADDR_L:    rd_dat = (state == S_DONE) ? l_next : l_reg;
            ADDR_CTRL: rd_dat = {29'b0, err, ready, valid};
            ADDR_GPIN: rd_dat = gpio_in_s_insp;
            default:   rd_dat = '0;
        endcase
    end

    // Registered read data, held until the next read strobe.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sdata_out <= '0;
        end else if (srd) begin
            sdata_out <= rd_dat;
        end
    end

    // GPIO snapshot on the rising edge of gpio_latch.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            gpio_latch_q   <= 1'b0;
            gpio_in_s_insp <= '0;
        end else begin
            gpio_latch_q <= gpio_latch;
            if (gpio_latch && !gpio_latch_q) gpio_in_s_insp <= gpio_in;
        end
    end

endmodule

// File: tb/tb_gpio_mul_popcnt.sv
module tb_gpio_mul_popcnt;

    localparam logic [15:0] A_A1   = 16'h0380;
    localparam logic [15:0] A_A2   = 16'h0388;
    localparam logic [15:0] A_W    = 16'h0390;
    localparam logic [15:0] A_L    = 16'h0398;
    localparam logic [15:0] A_CTRL = 16'h03A0;
    localparam logic [15:0] A_GPIN = 16'h03A8;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [15:0] saddress;
    logic        srd, swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;
    logic [31:0] gpio_in;
    logic        gpio_latch;
    logic [31:0] gpio_in_s_insp;
    logic [31:0] gpio_out;

    int checks   = 0;
    int failures = 0;

    gpio_mul_popcnt #(.OPW(24), .RW(32), .BASE(16'h0380)) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .saddress       (saddress),
        .srd            (srd),
        .swr            (swr),
        .sdata_in       (sdata_in),
        .sdata_out      (sdata_out),
        .gpio_in        (gpio_in),
        .gpio_latch     (gpio_latch),
        .gpio_in_s_insp (gpio_in_s_insp),
        .gpio_out       (gpio_out)
    );

    always #5 clk = ~clk;

    // All bus tasks are entered at a negedge and return at the following negedge.
    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
        saddress = addr; sdata_in = data; swr = 1'b1;
        @(negedge clk);
        swr = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
        saddress = addr; srd = 1'b1;
        @(negedge clk);
        srd = 1'b0;
        data = sdata_out;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Polls STATUS once per clk; k is the cycle offset after START at which ready was first seen (0 = timeout).
    task automatic poll_ready(output int k, output logic [31:0] st);
        k = 0;
        st = '0;
        for (int i = 1; i <= 100; i++) begin
            bus_read(A_CTRL, st);
            if (st[1]) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [31:0] a1, input logic [31:0] a2, output int k, output logic [31:0] st);
        bus_write(A_A1, a1);
        bus_write(A_A2, a2);
        bus_write(A_CTRL, 32'd1);
        poll_ready(k, st);
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        checks++; if (sdata_out !== 32'd0) begin failures++; $display("FAIL reset_sdata_out: got %h want 0", sdata_out); end
        checks++; if (gpio_out !== 32'd0) begin failures++; $display("FAIL reset_gpio_out: got %h want 0", gpio_out); end
        checks++; if (gpio_in_s_insp !== 32'd0) begin failures++; $display("FAIL reset_insp: got %h want 0", gpio_in_s_insp); end
        bus_read(A_CTRL, rd);
        checks++; if (rd !== 32'd3) begin failures++; $display("FAIL reset_status: got %h want 3", rd); end
        bus_read(A_W, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_w: got %h want 0", rd); end
    endtask

    task automatic test_mul_basic;
        int k; logic [31:0] st, rd;
        run_op(32'd3, 32'd5, k, st);
        checks++; if (k !== 27) begin failures++; $display("FAIL basic_latency: got %0d want 27", k); end
        checks++; if (st !== 32'd3) begin failures++; $display("FAIL basic_status: got %h want 3", st); end
        bus_read(A_W, rd);
        checks++; if (rd !== 32'd15) begin failures++; $display("FAIL basic_w: got %h want f", rd); end
        bus_read(A_L, rd);
        checks++; if (rd !== 32'd4) begin failures++; $display("FAIL basic_l: got %h want 4", rd); end
        checks++; if (gpio_out !== 32'd1) begin failures++; $display("FAIL basic_gpio_out: got %h want 1", gpio_out); end
    endtask

    task automatic test_overflow;
        int k; logic [31:0] st, rd;
        run_op(32'h00FF_FFFF, 32'h00FF_FFFF, k, st);
        checks++; if (st !== 32'd2) begin failures++; $display("FAIL ovf_status: got %h want 2", st); end
        bus_read(A_W, rd);
        checks++; if (rd !== 32'hFE00_0001) begin failures++; $display("FAIL ovf_w: got %h want fe000001", rd); end
        bus_read(A_L, rd);
        checks++; if (rd !== 32'd8) begin failures++; $display("FAIL ovf_l: got %h want 8", rd); end
        // 0 x 0 with upper operand bits set in sdata_in (must be ignored), L read exactly in DONE.
        bus_write(A_A1, 32'hFF00_0000);
        bus_write(A_A2, 32'h0000_0000);
        bus_write(A_CTRL, 32'd1);
        wait_cycles(25);
        bus_read(A_L, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL done_bypass_l: got %h want 0", rd); end
        poll_ready(k, st);
        checks++; if (k !== 1) begin failures++; $display("FAIL zero_ready_offset: got %0d want 1", k); end
        checks++; if (st !== 32'd3) begin failures++; $display("FAIL zero_status: got %h want 3", st); end
        bus_read(A_W, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL zero_w: got %h want 0", rd); end
        checks++; if (gpio_out !== 32'd3) begin failures++; $display("FAIL zero_gpio_out: got %h want 3", gpio_out); end
    endtask

    task automatic test_busy_start;
        int k; logic [31:0] st, rd;
        bus_write(A_A1, 32'd6);
        bus_write(A_A2, 32'd9);
        bus_write(A_CTRL, 32'd1);   // cycle N
        bus_write(A_A1, 32'd7);     // cycle N+1, shadow only
        wait_cycles(3);
        bus_write(A_CTRL, 32'd1);   // cycle N+5, rejected
        poll_ready(k, st);
        checks++; if (st !== 32'd7) begin failures++; $display("FAIL busy_status: got %h want 7", st); end
        bus_read(A_W, rd);
        checks++; if (rd !== 32'd54) begin failures++; $display("FAIL busy_w: got %h want 36", rd); end
        bus_read(A_L, rd);
        checks++; if (rd !== 32'd4) begin failures++; $display("FAIL busy_l: got %h want 4", rd); end
        bus_write(A_CTRL, 32'd1);
        poll_ready(k, st);
        checks++; if (st !== 32'd3) begin failures++; $display("FAIL err_clear_status: got %h want 3", st); end
        bus_read(A_W, rd);
        checks++; if (rd !== 32'd63) begin failures++; $display("FAIL shadow_w: got %h want 3f", rd); end
        bus_read(A_L, rd);
        checks++; if (rd !== 32'd6) begin failures++; $display("FAIL shadow_l: got %h want 6", rd); end
        checks++; if (gpio_out !== 32'd5) begin failures++; $display("FAIL busy_gpio_out: got %h want 5", gpio_out); end
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd;
        bus_write(A_A1, 32'd5);
        bus_write(A_A2, 32'd5);
        bus_write(A_CTRL, 32'd1);
        wait_cycles(9);
        n_reset = 1'b0;
        #1;
        checks++; if (sdata_out !== 32'd0) begin failures++; $display("FAIL abort_sdata_out: got %h want 0", sdata_out); end
        checks++; if (gpio_out !== 32'd0) begin failures++; $display("FAIL abort_gpio_out: got %h want 0", gpio_out); end
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        bus_read(A_CTRL, rd);
        checks++; if (rd !== 32'd3) begin failures++; $display("FAIL abort_status: got %h want 3", rd); end
        bus_read(A_L, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL abort_l: got %h want 0", rd); end
        wait_cycles(40);
        checks++; if (gpio_out !== 32'd0) begin failures++; $display("FAIL abort_gpio_hold: got %h want 0", gpio_out); end
    endtask

    task automatic test_wrap_unmapped;
        int k; logic [31:0] st, rd;
        force dut.gpio_out = 32'hFFFF_FFFF;
        #1;
        release dut.gpio_out;
        @(negedge clk);
        run_op(32'd2, 32'd3, k, st);
        checks++; if (gpio_out !== 32'd0) begin failures++; $display("FAIL wrap_gpio_out: got %h want 0", gpio_out); end
        bus_read(A_W, rd);
        checks++; if (rd !== 32'd6) begin failures++; $display("FAIL wrap_w: got %h want 6", rd); end
        bus_read(16'h0300, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL unmapped_read: got %h want 0", rd); end
        bus_read(A_W, rd);
        bus_read(A_A1, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL wronly_read: got %h want 0", rd); end
    endtask

    task automatic test_gpio;
        logic [31:0] rd;
        gpio_in = 32'hA5A5_0F0F;
        @(negedge clk);
        gpio_latch = 1'b1;
        @(negedge clk);
        gpio_latch = 1'b0;
        checks++; if (gpio_in_s_insp !== 32'hA5A5_0F0F) begin failures++; $display("FAIL gpio_insp: got %h want a5a50f0f", gpio_in_s_insp); end
        bus_read(A_GPIN, rd);
        checks++; if (rd !== 32'hA5A5_0F0F) begin failures++; $display("FAIL gpio_read: got %h want a5a50f0f", rd); end
        gpio_in = 32'h1234_5678;
        wait_cycles(3);
        checks++; if (gpio_in_s_insp !== 32'hA5A5_0F0F) begin failures++; $display("FAIL gpio_hold: got %h want a5a50f0f", gpio_in_s_insp); end
    endtask

    initial begin
        n_reset    = 1'b0;
        saddress   = '0;
        srd        = 1'b0;
        swr        = 1'b0;
        sdata_in   = '0;
        gpio_in    = '0;
        gpio_latch = 1'b0;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        test_reset;
        test_mul_basic;
        test_overflow;
        test_busy_start;
        test_reset_abort;
        test_wrap_unmapped;
        test_gpio;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
